// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses imem and fills the IF/ID register.
// Optional fetch-fault detection is built when IF_FETCH_FAULT_EN is defined.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        flush,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_rd,
    output logic [31:0] pc_f,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        fetch_fault
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS * 4);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic [31:0] instr_next;
    logic [31:0] ifid_pc_next;
    logic [31:0] ifid_pc4_next;
    logic        valid_next;
    logic        fault_hold;
    logic        fault_detect;

    assign pc_plus4 = pc + 32'd4;
    assign imem_a   = pc;
    assign pc_f     = pc;

`ifdef IF_FETCH_FAULT_EN
    logic fault_q;

    // A range fault only counts when this edge would actually load imem_rd from pc.
    assign fault_hold   = fault_q;
    assign fault_detect = (redirect && (redirect_pc[1:0] != 2'b00))
                        || (!redirect && !flush && !stall && (pc >= IMEM_LIMIT));
    assign fetch_fault  = fault_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            fault_q <= 1'b0;
        else if (fault_detect)
            fault_q <= 1'b1;
    end

    logic unused_bits;
    assign unused_bits = 1'b0;
`else
    assign fault_hold   = 1'b0;
    assign fault_detect = 1'b0;
    assign fetch_fault  = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{redirect_pc[1:0], IMEM_LIMIT[0]};
`endif

    // Priority: fault lock-out, then redirect > flush > stall > normal fetch.
    always_comb begin
        pc_next       = pc;
        instr_next    = ifid_instr;
        ifid_pc_next  = ifid_pc;
        ifid_pc4_next = ifid_pc4;
        valid_next    = ifid_valid;
        if (fault_hold || fault_detect) begin
            instr_next = NOP_INSTR;
            valid_next = 1'b0;
        end else if (redirect) begin
            pc_next    = {redirect_pc[31:2], 2'b00};
            instr_next = NOP_INSTR;
            valid_next = 1'b0;
        end else if (flush) begin
            if (!stall)
                pc_next = pc_plus4;
            instr_next = NOP_INSTR;
            valid_next = 1'b0;
        end else if (!stall) begin
            pc_next       = pc_plus4;
            instr_next    = imem_rd;
            ifid_pc_next  = pc;
            ifid_pc4_next = pc_plus4;
            valid_next    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            ifid_instr <= NOP_INSTR;
            ifid_pc    <= 32'd0;
            ifid_pc4   <= 32'd4;
            ifid_valid <= 1'b0;
        end else begin
            pc         <= pc_next;
            ifid_instr <= instr_next;
            ifid_pc    <= ifid_pc_next;
            ifid_pc4   <= ifid_pc4_next;
            ifid_valid <= valid_next;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a rule-level model predicts each edge's state,
// a separate monitor compares the DUT against the queued predictions.
module tb_if_stage;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          WORDS = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic [31:0] pc_f;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        fetch_fault;

    logic [31:0] mem [0:WORDS-1];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic [31:0] ipc4;
        logic        valid;
        logic        fault;
    } snap_t;

    snap_t model;
    snap_t expq[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    if_stage #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .flush(flush), .imem_a(imem_a), .imem_rd(imem_rd),
        .pc_f(pc_f), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
        .ifid_valid(ifid_valid), .fetch_fault(fetch_fault)
    );

    assign imem_rd = mem[imem_a[7:2]];

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Next IF state derived straight from the stage's rules.
    function automatic snap_t predict(snap_t m, logic r, logic s, logic rd, logic f,
                                      logic [31:0] rpc, logic [31:0] word);
        snap_t n = m;
        if (!r) begin
            n.pc = 32'h0; n.instr = NOP; n.ipc = 32'h0; n.ipc4 = 32'h4;
            n.valid = 1'b0; n.fault = 1'b0;
            return n;
        end
`ifdef IF_FETCH_FAULT_EN
        if (m.fault || (rd && rpc[1:0] != 2'b00) ||
            (!rd && !f && !s && m.pc >= 32'(WORDS * 4))) begin
            n.fault = 1'b1; n.instr = NOP; n.valid = 1'b0;
            return n;
        end
`endif
        if (rd) begin
            n.pc = rpc & ~32'd3; n.instr = NOP; n.valid = 1'b0;
        end else if (f) begin
            if (!s) n.pc = m.pc + 32'd4;
            n.instr = NOP; n.valid = 1'b0;
        end else if (!s) begin
            n.instr = word; n.ipc = m.pc; n.ipc4 = m.pc + 32'd4;
            n.pc = m.pc + 32'd4; n.valid = 1'b1;
        end
        return n;
    endfunction

    task automatic applyStimulus(input logic r, input logic s, input logic rd, input logic f,
                                 input logic [31:0] rpc);
        @(negedge clk);
        rst_n = r; stall = s; redirect = rd; flush = f; redirect_pc = rpc;
        model = predict(model, r, s, rd, f, rpc, mem[model.pc[7:2]]);
        expq.push_back(model);
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checkOutput("pc_f", pc_f, e.pc);
                checkOutput("imem_a", imem_a, e.pc);
                checkOutput("ifid_instr", ifid_instr, e.instr);
                checkOutput("ifid_pc", ifid_pc, e.ipc);
                checkOutput("ifid_pc4", ifid_pc4, e.ipc4);
                checkOutput("ifid_valid", 32'(ifid_valid), 32'(e.valid));
                checkOutput("fetch_fault", 32'(fetch_fault), 32'(e.fault));
            end
        end
    end

    initial begin : driver
        logic        r, s, rd, f;
        logic [31:0] rpc;
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom();
        mem[0] = 32'h0050_0113;
        mem[1] = 32'h00C0_0193;
        mem[2] = 32'hFF71_8393;
        model = '{pc: 32'h0, instr: NOP, ipc: 32'h0, ipc4: 32'h4, valid: 1'b0, fault: 1'b0};

        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("first_instr", ifid_instr, 32'h0050_0113);
        checkOutput("first_pc4", ifid_pc4, 32'h4);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("third_instr", ifid_instr, 32'hFF71_8393);
        checkOutput("third_pc", ifid_pc, 32'h8);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("stall_addr", imem_a, 32'h10);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("release_ifid_pc", ifid_pc, 32'h10);
        checkOutput("release_pc", pc_f, 32'h14);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 32'h40);
        checkOutput("redir_pc", pc_f, 32'h40);
        checkOutput("redir_bubble", ifid_instr, NOP);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("redir_ifid_pc", ifid_pc, 32'h40);
        applyStimulus(1, 0, 1, 0, 32'h20);
        applyStimulus(1, 0, 0, 1, 0);
        checkOutput("flush_pc", pc_f, 32'h24);
        checkOutput("flush_valid", 32'(ifid_valid), 32'h0);
`ifndef IF_FETCH_FAULT_EN
        applyStimulus(1, 0, 1, 0, 32'hFFFF_FFFC);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("wrap_pc", pc_f, 32'h0);
`endif
        applyStimulus(1, 0, 1, 0, 32'h30);
        applyStimulus(0, 0, 1, 0, 32'h44);
        checkOutput("rst_pc", pc_f, 32'h0);
        checkOutput("rst_pc4", ifid_pc4, 32'h4);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("post_rst_fetch", ifid_pc, 32'h0);
        applyStimulus(1, 0, 1, 0, 32'h42);
`ifdef IF_FETCH_FAULT_EN
        checkOutput("fault_set", 32'(fetch_fault), 32'h1);
        checkOutput("fault_pc_hold", pc_f, 32'h4);
        applyStimulus(1, 0, 1, 0, 32'h0);
        checkOutput("fault_ignore_redir", pc_f, 32'h4);
`else
        checkOutput("align_pc", pc_f, 32'h40);
        checkOutput("no_fault", 32'(fetch_fault), 32'h0);
`endif

        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 99) >= 3);
            s   = ($urandom_range(0, 99) < 20);
            rd  = ($urandom_range(0, 99) < 12);
            f   = ($urandom_range(0, 99) < 8);
            rpc = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, WORDS - 1)) * 32'd4;
            applyStimulus(r, s, rd, f, rpc);
        end

        @(posedge clk);
        #3;
        checkOutput("queue_drained", 32'(expq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage. Owns the program counter and drives the word-aligned address into the combinational instruction memory `imem`.
- Registers the returned instruction word into the IF/ID pipeline register consumed by decode.
- Supports hazard stall, branch/jump redirect, and flush.
- One instruction fetched per cycle; fetch-to-decode latency is 1 cycle.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_WORDS, 64, depth of instruction memory in 32-bit words (used by fault check)
NOP_INSTR, 32'h0000_0013, encoding (addi x0,x0,0) inserted as a bubble

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
stall  input  1  hold PC and IF/ID contents (from hazard unit)
redirect  input  1  taken branch / jump resolved downstream
redirect_pc  input  32  target address for redirect
flush  input  1  kill IF/ID contents without changing PC sequence
imem_a  output  32  address to imem (= current PC, combinational from PC register)
imem_rd  input  32  instruction word returned by imem, same cycle
pc_f  output  32  current fetch PC (= imem_a)
ifid_instr  output  32  registered instruction to decode
ifid_pc  output  32  PC of ifid_instr
ifid_pc4  output  32  ifid_pc + 4
ifid_valid  output  1  IF/ID holds a real instruction
fetch_fault  output  1  fetch fault flag (FETCH_FAULT_EN only; tied 0 otherwise)

Behaviour:
- Clock and reset: all state updates on the rising edge of clk. Reset is synchronous, active-low.
- Reset (rst_n=0 at an edge), which overrides everything:
  - pc <= RESET_PC
  - ifid_instr <= NOP_INSTR
  - ifid_pc <= 0, ifid_pc4 <= 4
  - ifid_valid <= 0, fetch_fault <= 0
  - Reset asserted mid-stall or mid-redirect discards that event; the first fetch after deassertion is from RESET_PC.
- Address path: imem_a = pc_f = pc. No combinational path from any input to imem_a.
- Priority per edge, when not in reset: redirect > flush > stall > normal.
- Normal (no redirect, flush or stall):
  - pc <= pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
  - ifid_instr <= imem_rd, ifid_pc <= pc, ifid_pc4 <= pc + 4, ifid_valid <= 1.
- Stall:
  - pc and all ifid_* hold their values.
  - imem_a stays constant, so imem_rd is re-read next cycle.
- Redirect:
  - pc <= {redirect_pc[31:2], 2'b00}.
  - IF/ID is loaded with a bubble: ifid_instr <= NOP_INSTR, ifid_valid <= 0; ifid_pc/ifid_pc4 hold.
  - Redirect asserted together with stall: redirect wins and stall is ignored for that edge.
  - Penalty is 1 bubble in IF/ID. Killing younger stages is their own responsibility.
- Flush without redirect:
  - Bubble is inserted into IF/ID as above.
  - pc advances normally (pc+4) unless stall is also high, in which case pc holds.
- Back-to-back redirects on consecutive cycles: each one reloads pc and the IF/ID bubble persists.
- ifid_valid=0 always accompanies ifid_instr=NOP_INSTR.

Optional Feature:
- Macro: IF_FETCH_FAULT_EN.
- Defined:
  - A fault is detected on any edge where redirect=1 and redirect_pc[1:0]!=0, or where the fetch would load from pc >= IMEM_WORDS*4.
  - fetch_fault is set to 1 and is sticky until reset.
  - While fetch_fault=1: pc holds, IF/ID receives NOP_INSTR with ifid_valid=0 every cycle, and stall, redirect and flush are ignored.
- Not defined:
  - fetch_fault is tied 0.
  - Misaligned redirect targets are silently aligned.
  - No range check; pc runs past IMEM_WORDS unchecked.

Test Plan:
- Reset then 3 free-running cycles (words 0..2 = 0x00500113, 0x00C00193, 0xFF718393) -> imem_a 0x0,0x4,0x8; after cycle 1 ifid_instr=0x00500113, ifid_pc=0, ifid_pc4=4, ifid_valid=1; after cycle 3 ifid_instr=0xFF718393, ifid_pc=8.
- stall held 2 cycles at pc=0x10 -> imem_a stays 0x10; ifid_* unchanged; on release, next edge ifid_pc=0x10, pc=0x14.
- redirect=1, redirect_pc=0x40 while stall=1 at pc=0x18 -> next edge pc=0x40, ifid_valid=0, ifid_instr=0x00000013; following edge ifid_pc=0x40.
- flush=1 alone at pc=0x20 -> pc=0x24, ifid_valid=0; pc=0xFFFFFFFC free-run -> pc wraps to 0x0.
- rst_n=0 for 1 cycle mid-stream at pc=0x30 with redirect=1 -> pc=RESET_PC, ifid_valid=0, ifid_pc4=4.
- IF_FETCH_FAULT_EN: redirect_pc=0x42 -> fetch_fault=1, pc holds, ifid_valid stays 0 while later redirect to 0x0 is ignored. Without the macro: same stimulus -> pc=0x40, fetch_fault=0.
